// File: rtl/candy_id_pkg.sv
// candy_id_pkg: shared definitions for the candy instruction-decode stage.
//   fmt_e    : 2-bit instruction format code (R/I/S/U), taken from the top
//              two bits of the raw instruction.
//   OP_IS_W  : op-field width of I and S formats.
//   OP_U_W   : op-field width of U format.
//   fmt_en() : per-format source-read / destination-write enables.
package candy_id_pkg;

    typedef enum logic [1:0] {
        FMT_R = 2'b00,
        FMT_I = 2'b01,
        FMT_S = 2'b10,
        FMT_U = 2'b11
    } fmt_e;

    localparam int OP_IS_W = 4;
    localparam int OP_U_W  = 2;

    // {re1, re2, we}
    function automatic logic [2:0] fmt_en(input fmt_e f);
        case (f)
            FMT_R:   return 3'b111;
            FMT_I:   return 3'b101;
            FMT_S:   return 3'b110;
            default: return 3'b001;
        endcase
    endfunction

endpackage

// File: rtl/candy_id_skid.sv
// candy_id_skid: generic 2-entry skid buffer (head + skid) with valid/ready
// handshakes on both sides and a flush.
//   clk, rst              clock, synchronous active-high reset
//   flush                 invalidate both entries next cycle (beats in_fire)
//   in_valid/in_ready     upstream handshake; in_ready = !skid_valid (a flop)
//   in_data[WIDTH]        payload captured on in_valid && in_ready
//   out_valid/out_ready   downstream handshake; out_valid = head valid
//   out_data[WIDTH]       head payload, stable while stalled
// Payload registers reset to zero so a freshly reset stage drives zeros.
module candy_id_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             head_valid, skid_valid;
    logic [WIDTH-1:0] head_data, skid_data;
    logic             in_fire, out_fire;

    assign in_ready  = ~skid_valid;
    assign out_valid = head_valid;
    assign out_data  = head_data;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = head_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_fire) begin
            // in_fire cannot coincide with a full skid (in_ready is low then)
            if (skid_valid) begin
                head_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                head_data  <= in_data;
            end else begin
                head_valid <= 1'b0;
            end
        end else if (in_fire) begin
            if (!head_valid) begin
                head_valid <= 1'b1;
                head_data  <= in_data;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
        end
    end

endmodule

// File: rtl/candy_id_pipe.sv
// candy_id_pipe: handshaked instruction-decode stage of the candy core.
// Decodes a raw instruction combinationally into op/fmt/register addresses/
// immediate/enables and registers the result toward execute through a
// 2-entry skid buffer (1-cycle latency, 1/cycle throughput).
//   clk, rst            clock, synchronous active-high reset
//   flush               drop everything buffered (and a same-cycle input)
//   in_valid/in_ready   fetch handshake, in_ready registered
//   inst[INST_W]        raw instruction, type = inst[INST_W-1 -: 2]
//   out_valid/out_ready execute handshake
//   op, fmt, rs1, rs2, rd, imm, re1, re2, we, illegal   decoded head entry
//   wb_valid, wb_rd     writeback retire port (CANDY_ID_HAZARD_EN only)
// Build option: define CANDY_ID_HAZARD_EN to add a busy scoreboard that
// holds the head while it reads a register with a write still in flight.
module candy_id_pipe
    import candy_id_pkg::*;
#(
    parameter int INST_W = 24,
    parameter int RA_W   = 4,
    parameter int OP_W   = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   op,
    output logic [1:0]        fmt,
    output logic [RA_W-1:0]   rs1,
    output logic [RA_W-1:0]   rs2,
    output logic [RA_W-1:0]   rd,
    output logic [DATA_W-1:0] imm,
    output logic              re1,
    output logic              re2,
    output logic              we,
    output logic              illegal
`ifdef CANDY_ID_HAZARD_EN
    ,
    input  logic              wb_valid,
    input  logic [RA_W-1:0]   wb_rd
`endif
);

    localparam int FREE     = INST_W - 2;
    localparam int RSV_W    = FREE - OP_W - 3*RA_W;
    localparam int IMM_IS_W = FREE - OP_IS_W - 2*RA_W;
    localparam int IMM_U_W  = FREE - OP_U_W - RA_W;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        fmt_e              fmt;
        logic [RA_W-1:0]   rs1;
        logic [RA_W-1:0]   rs2;
        logic [RA_W-1:0]   rd;
        logic [DATA_W-1:0] imm;
        logic              re1;
        logic              re2;
        logic              we;
        logic              illegal;
    } dec_t;

    dec_t dec, head;
    fmt_e typ;
    logic rsv_bad;
    logic head_valid, hold, skid_out_ready;

    // ---------------- decode ----------------
    assign typ = fmt_e'(inst[INST_W-1 -: 2]);

    logic [OP_W-1:0]            r_op;
    logic [RA_W-1:0]            r_rs1, r_rs2, r_rd;
    logic [OP_IS_W-1:0]         is_op;
    logic [RA_W-1:0]            is_rs1, is_f2;   // is_f2: rd for I, rs2 for S
    logic signed [IMM_IS_W-1:0] is_imm;
    logic [OP_U_W-1:0]          u_op;
    logic [RA_W-1:0]            u_rd;
    logic [IMM_U_W-1:0]         u_imm;

    assign r_op   = inst[FREE-1 -: OP_W];
    assign r_rs1  = inst[FREE-OP_W-1 -: RA_W];
    assign r_rs2  = inst[FREE-OP_W-RA_W-1 -: RA_W];
    assign r_rd   = inst[FREE-OP_W-2*RA_W-1 -: RA_W];
    assign is_op  = inst[FREE-1 -: OP_IS_W];
    assign is_rs1 = inst[FREE-OP_IS_W-1 -: RA_W];
    assign is_f2  = inst[FREE-OP_IS_W-RA_W-1 -: RA_W];
    assign is_imm = $signed(inst[IMM_IS_W-1:0]);
    assign u_op   = inst[FREE-1 -: OP_U_W];
    assign u_rd   = inst[FREE-OP_U_W-1 -: RA_W];
    assign u_imm  = inst[IMM_U_W-1:0];

    generate
        if (RSV_W > 0) begin : g_rsv
            assign rsv_bad = |inst[RSV_W-1:0];
        end else begin : g_no_rsv
            assign rsv_bad = 1'b0;
        end
    endgenerate

    always_comb begin
        dec = '0;
        dec.fmt = typ;
        {dec.re1, dec.re2, dec.we} = fmt_en(typ);
        unique case (typ)
            FMT_R: begin
                dec.op      = r_op;
                dec.rs1     = r_rs1;
                dec.rs2     = r_rs2;
                dec.rd      = r_rd;
                dec.illegal = rsv_bad;
            end
            FMT_I: begin
                dec.op  = OP_W'(is_op);
                dec.rs1 = is_rs1;
                dec.rd  = is_f2;
                dec.imm = DATA_W'(is_imm);   // signed source: sign-extends
            end
            FMT_S: begin
                dec.op  = OP_W'(is_op);
                dec.rs1 = is_rs1;
                dec.rs2 = is_f2;
                dec.imm = DATA_W'(is_imm);
            end
            FMT_U: begin
                dec.op  = OP_W'(u_op);
                dec.rd  = u_rd;
                dec.imm = DATA_W'(u_imm);    // unsigned: zero-extend/truncate
            end
        endcase
    end

    // ---------------- buffer ----------------
    candy_id_skid #(.WIDTH($bits(dec_t))) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec),
        .out_valid (head_valid),
        .out_ready (skid_out_ready),
        .out_data  (head)
    );

    // A held head must not leave, so the buffer sees out_ready gated too.
    assign out_valid      = head_valid & ~hold;
    assign skid_out_ready = out_ready & ~hold;

    // ---------------- hazard scoreboard ----------------
`ifdef CANDY_ID_HAZARD_EN
    localparam int NREG = 1 << RA_W;

    logic [NREG-1:0] busy, busy_set, busy_clr, busy_nxt;

    assign hold = (head.re1 & busy[head.rs1]) | (head.re2 & busy[head.rs2]);

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (out_valid && out_ready && head.we && head.rd != '0)
            busy_set[head.rd] = 1'b1;
        if (wb_valid)
            busy_clr[wb_rd] = 1'b1;
        busy_nxt    = (busy & ~busy_clr) | busy_set;   // set beats clear
        busy_nxt[0] = 1'b0;
    end

    // flush leaves busy alone: the writes already issued still retire
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end
`else
    assign hold = 1'b0;
`endif

    assign op      = head.op;
    assign fmt     = head.fmt;
    assign rs1     = head.rs1;
    assign rs2     = head.rs2;
    assign rd      = head.rd;
    assign imm     = head.imm;
    assign re1     = head.re1;
    assign re2     = head.re2;
    assign we      = head.we;
    assign illegal = head.illegal;

endmodule

// File: tb/tb_candy_id_pipe.sv
// Directed bench for candy_id_pipe (INST_W=24 RA_W=4 OP_W=6 DATA_W=16).
// Expected decodes are hand-derived constants queued on input fire and
// compared in order on output fire. Define CANDY_ID_HAZARD_EN for both
// the DUT and this bench to exercise the scoreboard.
module tb_candy_id_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [23:0] inst;
    logic [5:0]  op;
    logic [1:0]  fmt;
    logic [3:0]  rs1, rs2, rd;
    logic [15:0] imm;
    logic        re1, re2, we, illegal;
`ifdef CANDY_ID_HAZARD_EN
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        auto_wb, last_wb;
    logic [3:0]  last_rd;
`endif

    always #5 clk = ~clk;

    candy_id_pipe #(.INST_W(24), .RA_W(4), .OP_W(6), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .op(op), .fmt(fmt), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .re1(re1), .re2(re2), .we(we), .illegal(illegal)
`ifdef CANDY_ID_HAZARD_EN
        , .wb_valid(wb_valid), .wb_rd(wb_rd)
`endif
    );

    int checks = 0;
    int failures = 0;
    int delivered = 0;
    logic [39:0] exp_q[$];
    logic [39:0] pend;

    function automatic logic [39:0] mk(input logic [5:0] o, input logic [1:0] f,
                                       input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] d, input logic [15:0] im,
                                       input logic e1, input logic e2,
                                       input logic w, input logic il);
        return {o, f, a, b, d, im, e1, e2, w, il};
    endfunction

    function automatic logic [39:0] got();
        return {op, fmt, rs1, rs2, rd, imm, re1, re2, we, illegal};
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        chk(tag, {39'd0, obs}, {39'd0, expv});
    endtask

    // One clock: sample handshakes at the falling edge, then step past the
    // rising edge.
    task automatic cyc(output logic fired);
        logic [39:0] e;
        @(negedge clk);
        fired = in_valid && in_ready && !rst;
        if (fired && !flush) exp_q.push_back(pend);
`ifdef CANDY_ID_HAZARD_EN
        last_wb = 1'b0;
`endif
        if (out_valid && out_ready && !rst) begin
            delivered++;
`ifdef CANDY_ID_HAZARD_EN
            last_wb = we && (rd != 4'd0);
            last_rd = rd;
`endif
            chk1("sb_expected_output", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_decode", got(), e);
            end
        end
        @(posedge clk);
        #1;
        if (flush || rst) exp_q.delete();
`ifdef CANDY_ID_HAZARD_EN
        if (auto_wb) begin
            wb_valid = last_wb;
            wb_rd    = last_rd;
        end
`endif
    endtask

    task automatic idle(input int n);
        logic f;
        repeat (n) cyc(f);
    endtask

    task automatic send(input logic [23:0] i, input logic [39:0] e);
        logic f;
        int n;
        n = 0;
        in_valid = 1'b1;
        inst = i;
        pend = e;
        do begin
            cyc(f);
            n++;
        end while (!f && n < 20);
        chk1("send_accepted", f, 1'b1);
        in_valid = 1'b0;
    endtask

    localparam logic [39:0] E_R1 = mk(6'h05, 2'd0, 4'd3, 4'd2, 4'd1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
    localparam logic [39:0] E_RX = mk(6'h05, 2'd0, 4'd3, 4'd2, 4'd1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
    localparam logic [39:0] E_R2 = mk(6'h01, 2'd0, 4'd1, 4'd0, 4'd2, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
    localparam logic [39:0] E_I1 = mk(6'h02, 2'd1, 4'd1, 4'd0, 4'd5, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    localparam logic [39:0] E_I2 = mk(6'h0F, 2'd1, 4'hA, 4'd0, 4'hB, 16'h007F, 1'b1, 1'b0, 1'b1, 1'b0);
    localparam logic [39:0] E_S1 = mk(6'h03, 2'd2, 4'd4, 4'd6, 4'd0, 16'hFE00, 1'b1, 1'b1, 1'b0, 1'b0);
    localparam logic [39:0] E_U1 = mk(6'h01, 2'd3, 4'd0, 4'd0, 4'd7, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
    localparam logic [39:0] E_U2 = mk(6'h02, 2'd3, 4'd0, 4'd0, 4'd2, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0);

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic f;
        int d0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inst = '0; pend = '0;
`ifdef CANDY_ID_HAZARD_EN
        wb_valid = 1'b0; wb_rd = '0; auto_wb = 1'b1; last_wb = 1'b0; last_rd = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk("rst_outputs", got(), 40'd0);

        // single R, 1-cycle latency
        out_ready = 1'b1;
        send(24'h053210, E_R1);
        chk1("latency_out_valid", out_valid, 1'b1);

        // streaming through every format, including an illegal R
        send(24'h4857FF, E_I1);
        send(24'hD78000, E_U1);
        send(24'h053211, E_RX);
        send(24'h8D1A00, E_S1);
        send(24'hE21234, E_U2);
        send(24'h7EAC7F, E_I2);
        idle(4);
        chk("stream_drained", 40'(exp_q.size()), 40'd0);

        // backpressure: two buffered, in_ready drops after the 2nd accept
        out_ready = 1'b0;
        send(24'h8D1A00, E_S1);
        chk1("bp_ready_after_1", in_ready, 1'b1);
        send(24'hE21234, E_U2);
        chk1("bp_ready_after_2", in_ready, 1'b0);
        in_valid = 1'b1; inst = 24'h7EAC7F; pend = E_I2;
        cyc(f);
        cyc(f);
        chk1("bp_no_accept", f, 1'b0);
        chk1("bp_ready_held", in_ready, 1'b0);
        chk1("bp_out_valid", out_valid, 1'b1);
        chk("bp_head_stable", got(), E_S1);
        out_ready = 1'b1;
        d0 = delivered;
        send(24'h7EAC7F, E_I2);
        send(24'h4857FF, E_I1);
        cyc(f);
        chk("bp_drain_rate", 40'(delivered - d0), 40'd4);

        // flush with both entries full
        out_ready = 1'b0;
        send(24'hD78000, E_U1);
        send(24'h053211, E_RX);
        in_valid = 1'b1; inst = 24'h7EAC7F; pend = E_I2; flush = 1'b1;
        cyc(f);
        flush = 1'b0; in_valid = 1'b0;
        chk1("flush_full_out_valid", out_valid, 1'b0);
        chk1("flush_full_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        d0 = delivered;
        idle(3);
        chk("flush_full_nothing_out", 40'(delivered - d0), 40'd0);

        // flush with only head full and a same-cycle accepted input
        out_ready = 1'b0;
        send(24'hD78000, E_U1);
        in_valid = 1'b1; inst = 24'h053210; pend = E_R1; flush = 1'b1;
        cyc(f);
        flush = 1'b0; in_valid = 1'b0;
        chk1("flush_fire_seen", f, 1'b1);
        chk1("flush_head_out_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        d0 = delivered;
        idle(3);
        chk("flush_head_nothing_out", 40'(delivered - d0), 40'd0);
        send(24'hE21234, E_U2);
        idle(2);
        chk("post_flush_delivered", 40'(delivered - d0), 40'd1);

        // reset mid-stream
        out_ready = 1'b0;
        send(24'h8D1A00, E_S1);
        rst = 1'b1;
        cyc(f);
        rst = 1'b0;
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk1("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_outputs", got(), 40'd0);
        out_ready = 1'b1;
        d0 = delivered;
        idle(2);
        chk("midrst_nothing_out", 40'(delivered - d0), 40'd0);

`ifdef CANDY_ID_HAZARD_EN
        // RAW on r1: second instruction held until writeback retires r1
        auto_wb = 1'b0;
        wb_valid = 1'b0;
        send(24'h053210, E_R1);
        cyc(f);
        send(24'h011020, E_R2);
        chk1("haz_held_0", out_valid, 1'b0);
        cyc(f);
        chk1("haz_held_1", out_valid, 1'b0);
        cyc(f);
        chk1("haz_held_2", out_valid, 1'b0);
        wb_valid = 1'b1; wb_rd = 4'd1;
        cyc(f);
        wb_valid = 1'b0;
        chk1("haz_released", out_valid, 1'b1);
        cyc(f);
`endif

        idle(2);
        chk("final_drained", 40'(exp_q.size()), 40'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
